// File: rtl/cpu_run_checker.sv
// Run controller for mips_cpu_harvard instruction tests: sequences CPU reset, checks the
// reset vector, an optional first data address, the halt value of v0 and a cycle timeout.
module cpu_run_checker #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
   parameter int                RESET_CYCLES = 2,
   parameter int                TIMEOUT      = 1000,
   parameter bit                CHECK_DADDR  = 1'b0,
   parameter int                CNT_W        = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              cpu_reset,
   output logic              cpu_clk_enable,
   input  logic              cpu_active,
   input  logic [ADDR_W-1:0] instr_address,
   input  logic [ADDR_W-1:0] data_address,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [DATA_W-1:0] register_v0,
   input  logic [DATA_W-1:0] expected_v0,
   input  logic [ADDR_W-1:0] expected_daddr,
   output logic              done,
   output logic              pass,
   output logic [2:0]        fail_code,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_VEC,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_VECTOR  = 3'd1;
   localparam logic [2:0] FC_TIMEOUT = 3'd2;
   localparam logic [2:0] FC_V0      = 3'd3;
   localparam logic [2:0] FC_DADDR   = 3'd4;
   localparam logic [2:0] FC_ACTIVE  = 3'd5;

   localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);

   state_t            state;
   logic [HOLD_W-1:0] hold_count;
   logic              daddr_seen;

   logic [CNT_W-1:0]  cnt_next;
   logic              daddr_check;
   logic              daddr_bad;
   logic              timed_out;
   logic              finish;
   logic [2:0]        finish_code;

   // The RUN counter saturates so a stalled CPU cannot wrap it back below TIMEOUT.
   assign cnt_next    = (cycle_count >= CNT_MAX) ? CNT_MAX : cycle_count + CNT_W'(1);
   assign daddr_check = CHECK_DADDR && !daddr_seen && (data_read || data_write);
   assign daddr_bad   = daddr_check && (data_address != expected_daddr);
   assign timed_out   = cpu_active && (cnt_next >= CNT_MAX);

   // Test verdict for this cycle; the priority order of the checks is encoded by the if-chains.
   always_comb begin
      finish      = 1'b0;
      finish_code = FC_NONE;
      case (state)
         S_VEC: begin
            if (!cpu_active) begin
               finish      = 1'b1;
               finish_code = FC_ACTIVE;
            end else if (instr_address != RESET_VECTOR) begin
               finish      = 1'b1;
               finish_code = FC_VECTOR;
            end
         end
         S_RUN: begin
            if (daddr_bad) begin
               finish      = 1'b1;
               finish_code = FC_DADDR;
            end else if (!cpu_active) begin
               finish      = 1'b1;
               finish_code = (register_v0 == expected_v0) ? FC_NONE : FC_V0;
            end else if (timed_out) begin
               finish      = 1'b1;
               finish_code = FC_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   // NOTE: non-blocking assignments throughout; the later finish block deliberately
   // overrides the state-case assignments because the last scheduled update wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cpu_reset      <= 1'b1;
         cpu_clk_enable <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_code      <= FC_NONE;
         cycle_count    <= '0;
         hold_count     <= '0;
         daddr_seen     <= 1'b0;
      end else if (abort) begin
         state          <= S_IDLE;
         cpu_reset      <= 1'b1;
         cpu_clk_enable <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_code      <= FC_NONE;
         hold_count     <= '0;
         daddr_seen     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_HOLD;
                  cpu_reset      <= 1'b1;
                  cpu_clk_enable <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_code      <= FC_NONE;
                  cycle_count    <= '0;
                  hold_count     <= '0;
                  daddr_seen     <= 1'b0;
               end
            end
            S_HOLD: begin
               if (hold_count == HOLD_LAST) begin
                  state      <= S_VEC;
                  cpu_reset  <= 1'b0;
                  hold_count <= '0;
               end else begin
                  hold_count <= hold_count + HOLD_W'(1);
               end
            end
            S_VEC: begin
               state <= S_RUN;
            end
            S_RUN: begin
               cycle_count <= cnt_next;
               if (daddr_check) begin
                  daddr_seen <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Freezing the CPU clock keeps register_v0 and the address buses inspectable in DONE.
         if (finish) begin
            state          <= S_DONE;
            done           <= 1'b1;
            pass           <= (finish_code == FC_NONE);
            fail_code      <= finish_code;
            cpu_clk_enable <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_checker.sv
// Directed bench for cpu_run_checker: a behavioural CPU stub driven by a table of test
// scenarios, plus hand-written sequences for reset timing, abort and asynchronous reset.
module tb_cpu_run_checker;

   localparam int CNT_W = 10;

   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic              cpu_reset;
   logic              cpu_clk_enable;
   logic              cpu_active;
   logic [31:0]       instr_address;
   logic [31:0]       data_address;
   logic              data_read;
   logic              data_write;
   logic [31:0]       register_v0;
   logic [31:0]       expected_v0;
   logic [31:0]       expected_daddr;
   logic              done;
   logic              pass;
   logic [2:0]        fail_code;
   logic [CNT_W-1:0]  cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_run_checker #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .RESET_VECTOR (32'hBFC00000),
      .RESET_CYCLES (2),
      .TIMEOUT      (1000),
      .CHECK_DADDR  (1'b1)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .cpu_reset      (cpu_reset),
      .cpu_clk_enable (cpu_clk_enable),
      .cpu_active     (cpu_active),
      .instr_address  (instr_address),
      .data_address   (data_address),
      .data_read      (data_read),
      .data_write     (data_write),
      .register_v0    (register_v0),
      .expected_v0    (expected_v0),
      .expected_daddr (expected_daddr),
      .done           (done),
      .pass           (pass),
      .fail_code      (fail_code),
      .cycle_count    (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CPU stub configuration; since_rel counts enabled CPU cycles after reset release,
   // so it is 0 in the vector-check cycle and k in the k-th run cycle.
   logic [31:0] cfg_vec_addr;
   logic        cfg_vec_inactive;
   int          cfg_halt_at;
   logic [31:0] cfg_v0;
   int          cfg_rd_at;
   logic [31:0] cfg_rd_addr;
   int          cfg_wr_at;
   logic [31:0] cfg_wr_addr;
   int          since_rel;

   always @(posedge clk or posedge cpu_reset) begin
      if (cpu_reset) since_rel <= 0;
      else if (cpu_clk_enable) since_rel <= since_rel + 1;
   end

   assign cpu_active    = !cpu_reset && !(cfg_vec_inactive && since_rel == 0) &&
                          (cfg_halt_at == 0 || since_rel < cfg_halt_at);
   assign instr_address = cfg_vec_addr + (32'(since_rel) << 2);
   assign register_v0   = cfg_v0;
   assign data_read     = !cpu_reset && cfg_rd_at != 0 && since_rel == cfg_rd_at;
   assign data_write    = !cpu_reset && cfg_wr_at != 0 && since_rel == cfg_wr_at;
   assign data_address  = data_read ? cfg_rd_addr : (data_write ? cfg_wr_addr : 32'h0);

   typedef struct {
      string       name;
      logic [31:0] vec_addr;
      logic        vec_inactive;
      int          halt_at;
      logic [31:0] v0;
      logic [31:0] exp_v0;
      int          rd_at;
      logic [31:0] rd_addr;
      int          wr_at;
      logic [31:0] wr_addr;
      logic        exp_pass;
      logic [2:0]  exp_code;
      int          exp_count;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic configure(input vec_t v);
      cfg_vec_addr     = v.vec_addr;
      cfg_vec_inactive = v.vec_inactive;
      cfg_halt_at      = v.halt_at;
      cfg_v0           = v.v0;
      expected_v0      = v.exp_v0;
      cfg_rd_at        = v.rd_at;
      cfg_rd_addr      = v.rd_addr;
      cfg_wr_at        = v.wr_at;
      cfg_wr_addr      = v.wr_addr;
   endtask

   // Returns at the falling edge of the first HOLD cycle.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, ".done_within_budget"}, 64'(done), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t good;
      logic [CNT_W-1:0] frozen;

      //            name                    vec_addr      inact halt  v0        exp_v0    rd  rd_addr       wr  wr_addr       pass  code  count
      vecs[0]  = '{"good_run",             32'hBFC00000, 1'b0, 20,   32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b1, 3'd0, 20};
      vecs[1]  = '{"bad_vector",           32'h00000000, 1'b0, 20,   32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b0, 3'd1, 0};
      vecs[2]  = '{"timeout",              32'hBFC00000, 1'b0, 0,    32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b0, 3'd2, 1000};
      vecs[3]  = '{"v0_mismatch",          32'hBFC00000, 1'b0, 30,   32'h23,   32'h24,   0,  32'h0,        0,  32'h0,        1'b0, 3'd3, 30};
      vecs[4]  = '{"halt_on_timeout",      32'hBFC00000, 1'b0, 1000, 32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b1, 3'd0, 1000};
      vecs[5]  = '{"daddr_ok",             32'hBFC00000, 1'b0, 15,   32'h5,    32'h5,    5,  32'h00001000, 8,  32'h00000004, 1'b1, 3'd0, 15};
      vecs[6]  = '{"daddr_bad_read",       32'hBFC00000, 1'b0, 15,   32'h5,    32'h5,    7,  32'h00001004, 0,  32'h0,        1'b0, 3'd4, 7};
      vecs[7]  = '{"daddr_bad_write",      32'hBFC00000, 1'b0, 15,   32'h5,    32'h5,    0,  32'h0,        9,  32'h00001004, 1'b0, 3'd4, 9};
      vecs[8]  = '{"daddr_beats_halt",     32'hBFC00000, 1'b0, 12,   32'h5,    32'h5,    12, 32'h00001004, 0,  32'h0,        1'b0, 3'd4, 12};
      vecs[9]  = '{"inactive_at_vec",      32'hBFC00000, 1'b1, 20,   32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b0, 3'd5, 0};
      vecs[10] = '{"inactive_and_bad_vec", 32'h00000000, 1'b1, 20,   32'h5,    32'h5,    0,  32'h0,        0,  32'h0,        1'b0, 3'd5, 0};
      vecs[11] = '{"halt_first_cycle",     32'hBFC00000, 1'b0, 1,    32'h7,    32'h7,    0,  32'h0,        0,  32'h0,        1'b1, 3'd0, 1};
      vecs[12] = '{"v0_mismatch_at_limit", 32'hBFC00000, 1'b0, 1000, 32'h1,    32'h2,    0,  32'h0,        0,  32'h0,        1'b0, 3'd3, 1000};

      good = vecs[0];
      expected_daddr = 32'h00001000;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      configure(vecs[1]);

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst.cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst.cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.pass", 64'(pass), 64'd0);
      check("rst.fail_code", 64'(fail_code), 64'd0);
      check("rst.cycle_count", 64'(cycle_count), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Exact reset-release timing, using a bad reset vector so the verdict lands right after VEC.
      pulse_start();
      check("seq.hold1.cpu_reset", 64'(cpu_reset), 64'd1);
      check("seq.hold1.cpu_clk_enable", 64'(cpu_clk_enable), 64'd1);
      @(negedge clk);
      check("seq.hold2.cpu_reset", 64'(cpu_reset), 64'd1);
      @(negedge clk);
      check("seq.vec.cpu_reset", 64'(cpu_reset), 64'd0);
      check("seq.vec.done", 64'(done), 64'd0);
      @(negedge clk);
      check("seq.after_vec.done", 64'(done), 64'd1);
      check("seq.after_vec.fail_code", 64'(fail_code), 64'd1);
      check("seq.after_vec.pass", 64'(pass), 64'd0);

      // Table of complete runs, each restarted from DONE.
      for (int i = 0; i < 13; i++) begin
         configure(vecs[i]);
         @(negedge clk);
         pulse_start();
         check({vecs[i].name, ".start.cpu_reset"}, 64'(cpu_reset), 64'd1);
         check({vecs[i].name, ".start.cpu_clk_enable"}, 64'(cpu_clk_enable), 64'd1);
         check({vecs[i].name, ".start.done"}, 64'(done), 64'd0);
         check({vecs[i].name, ".start.fail_code"}, 64'(fail_code), 64'd0);
         wait_done(vecs[i].name, 1100);
         check({vecs[i].name, ".pass"}, 64'(pass), 64'(vecs[i].exp_pass));
         check({vecs[i].name, ".fail_code"}, 64'(fail_code), 64'(vecs[i].exp_code));
         check({vecs[i].name, ".cycle_count"}, 64'(cycle_count), 64'(vecs[i].exp_count));
         check({vecs[i].name, ".cpu_clk_enable"}, 64'(cpu_clk_enable), 64'd0);
         check({vecs[i].name, ".cpu_reset"}, 64'(cpu_reset), 64'd0);
         frozen = cycle_count;
         repeat (3) @(negedge clk);
         check({vecs[i].name, ".held.cycle_count"}, 64'(cycle_count), 64'(frozen));
         check({vecs[i].name, ".held.done"}, 64'(done), 64'd1);
      end

      // Start ignored mid-run, then abort in RUN keeps cycle_count.
      configure(vecs[2]);
      pulse_start();
      repeat (5) @(negedge clk);
      check("abort.run3.cycle_count", 64'(cycle_count), 64'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort.start_ignored.cpu_reset", 64'(cpu_reset), 64'd0);
      check("abort.start_ignored.cycle_count", 64'(cycle_count), 64'd3);
      repeat (2) @(negedge clk);
      check("abort.run6.cycle_count", 64'(cycle_count), 64'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort.cpu_reset", 64'(cpu_reset), 64'd1);
      check("abort.cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.fail_code", 64'(fail_code), 64'd0);
      check("abort.cycle_count", 64'(cycle_count), 64'd5);
      repeat (3) @(negedge clk);
      check("abort.idle.cycle_count", 64'(cycle_count), 64'd5);

      // Start and abort together: abort wins and the block stays idle.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort.cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);
      check("start_abort.cpu_reset", 64'(cpu_reset), 64'd1);
      repeat (2) @(negedge clk);
      check("start_abort.idle.cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);

      // Asynchronous reset in the middle of a run, then a clean run.
      pulse_start();
      repeat (10) @(negedge clk);
      check("async.run8.cycle_count", 64'(cycle_count), 64'd7);
      #2 reset = 1'b1;
      #1;
      check("async.cpu_reset", 64'(cpu_reset), 64'd1);
      check("async.cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);
      check("async.done", 64'(done), 64'd0);
      check("async.cycle_count", 64'(cycle_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      configure(good);
      @(negedge clk);
      pulse_start();
      wait_done("async_rerun", 1100);
      check("async_rerun.pass", 64'(pass), 64'd1);
      check("async_rerun.cycle_count", 64'(cycle_count), 64'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_checker.md
Name: cpu_run_checker

Overview:
- Synthesizable self-checking harness controller for the mips_cpu_harvard core.
- Sequences CPU reset, checks the reset vector, optionally checks the first data-bus address (JR-style tests), counts cycles to halt, and compares register_v0 against an expected value.
- Replaces hand-written per-instruction bench sequencing with one parametrised block.
- Sits beside the DUT in every instruction test; outputs pass/fail/code for the bench or an FPGA LED.

Parameters:
- ADDR_W, 32, width of instruction/data address buses.
- DATA_W, 32, width of register_v0 and the expected value.
- RESET_VECTOR, 32'hBFC00000, required instr_address on the first cycle after CPU reset release.
- RESET_CYCLES, 2, cycles cpu_reset is held high (>=1).
- TIMEOUT, 1000, maximum RUN cycles before failure (>=1).
- CHECK_DADDR, 0, when 1, the first data_read or data_write in RUN must present expected_daddr.
- CNT_W, $clog2(TIMEOUT+1), cycle counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset of this block
- start  in  1  one-cycle pulse; begins a test from IDLE
- abort  in  1  returns to IDLE from any state, synchronous
- cpu_reset  out  1  drives DUT reset
- cpu_clk_enable  out  1  drives DUT clk_enable
- cpu_active  in  1  DUT active
- instr_address  in  ADDR_W  DUT instruction address
- data_address  in  ADDR_W  DUT data address
- data_read  in  1  DUT data read strobe
- data_write  in  1  DUT data write strobe
- register_v0  in  DATA_W  DUT v0 value
- expected_v0  in  DATA_W  value v0 must hold at halt; held stable during a test
- expected_daddr  in  ADDR_W  required first data address, used when CHECK_DADDR=1
- done  out  1  test finished; high in DONE
- pass  out  1  done and no failure
- fail_code  out  3  0 none, 1 bad reset vector, 2 timeout, 3 v0 mismatch, 4 data address mismatch, 5 active not asserted
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE

Behaviour:
- Reset values: state IDLE, cpu_reset=1, cpu_clk_enable=0, done=0, pass=0, fail_code=0, cycle_count=0, hold counter=0, daddr_seen=0.
- States: IDLE, HOLD, VEC, RUN, DONE. All outputs are registered.
- IDLE:
  - cpu_reset=1, cpu_clk_enable=0.
  - On start: go to HOLD, clear cycle_count, fail_code, done, pass and daddr_seen, and set cpu_clk_enable=1.
- HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES clocks, then cpu_reset=0 and go to VEC.
- VEC (one cycle, first after release):
  - If cpu_active=0, fail code 5.
  - Else if instr_address!=RESET_VECTOR, fail code 1.
  - Else go to RUN.
  - If both conditions fail, code 5 wins.
- RUN, each cycle:
  - cycle_count increments, saturating at TIMEOUT.
  - Halt: when cpu_active=0, compare register_v0 with expected_v0 in the same cycle. Equal gives pass; unequal gives fail code 3.
  - Data check (CHECK_DADDR=1): on the first cycle with data_read|data_write while daddr_seen=0, set daddr_seen. If data_address!=expected_daddr, fail code 4 immediately. Later accesses are not checked.
  - Timeout: if cycle_count reaches TIMEOUT with cpu_active still 1, fail code 2.
  - Priority in one cycle: code 4 > halt evaluation > timeout. A halt on the timeout cycle is evaluated as a halt, not a timeout.
- Fail or pass transition:
  - Next state DONE, done=1, pass=(fail_code==0), cpu_clk_enable=0 to freeze the DUT, cpu_reset stays 0.
- DONE:
  - Holds all outputs.
  - start restarts the test (goes to HOLD, clears results).
- abort: synchronous, any state → IDLE with reset-state outputs except cycle_count, which holds its last value.
- reset asserted mid-test: immediate asynchronous return to reset values. cpu_reset=1 therefore asserts the DUT reset asynchronously too.
- start outside IDLE/DONE is ignored. Simultaneous start and abort: abort wins.

Test Plan:
- Behavioural CPU stub presents 32'hBFC00000 after release, drops active at cycle 20 with v0=5; expected_v0=5 → done=1, pass=1, fail_code=0, cycle_count=20, cpu_clk_enable=0.
- Stub presents instr_address=0 after release → fail_code=1 in the cycle after VEC, pass=0.
- Stub never drops active, TIMEOUT=1000 → fail_code=2 at cycle_count=1000.
- Stub halts with v0=32'h23, expected_v0=32'h24 → fail_code=3. Also halt exactly on cycle 1000 with matching v0 → pass=1, not timeout.
- CHECK_DADDR=1, expected_daddr=32'h00001000:
  - First data_read at 32'h00001000, later read at 32'h4 → pass.
  - First access at 32'h00001004 → fail_code=4.
- reset pulsed mid-RUN → cpu_reset=1 and done=0 without a clock edge. Then start, then a valid run → pass=1. Also abort in RUN → IDLE with cycle_count held.
